// File: rtl/eaglesong_pkg.sv
// Shared widths, FSM state type and the 32-bit rotate helper for the
// Eaglesong circulant-multiplication block.
package eaglesong_pkg;

  localparam int WORD_W    = 32;
  localparam int NUM_WORDS = 16;
  localparam int STATE_W   = 512;
  localparam int COEF_W    = 5;
  localparam int IDX_W     = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Upper half of {x,x} << n is x rotated left by n; n = 0 yields x.
  function automatic logic [WORD_W-1:0] rotl32(input logic [WORD_W-1:0] x,
                                               input logic [COEF_W-1:0] n);
    logic [2*WORD_W-1:0] d;
    d = {x, x} << n;
    return d[2*WORD_W-1:WORD_W];
  endfunction

endpackage

// File: rtl/eaglesong_coefficients.sv
// Combinational lookup of the 48-entry circulant rotate-amount table.
// Indices outside 0..47 return 0.
module eaglesong_coefficients
  import eaglesong_pkg::*;
(
  input  logic [IDX_W-1:0]  idx_i,
  output logic [COEF_W-1:0] coef_o
);

  always_comb begin
    coef_o = '0;
    case (idx_i)
      7'd0:  coef_o = 5'd0;   7'd1:  coef_o = 5'd2;   7'd2:  coef_o = 5'd4;
      7'd3:  coef_o = 5'd0;   7'd4:  coef_o = 5'd13;  7'd5:  coef_o = 5'd22;
      7'd6:  coef_o = 5'd0;   7'd7:  coef_o = 5'd4;   7'd8:  coef_o = 5'd19;
      7'd9:  coef_o = 5'd0;   7'd10: coef_o = 5'd3;   7'd11: coef_o = 5'd14;
      7'd12: coef_o = 5'd0;   7'd13: coef_o = 5'd27;  7'd14: coef_o = 5'd31;
      7'd15: coef_o = 5'd0;   7'd16: coef_o = 5'd3;   7'd17: coef_o = 5'd8;
      7'd18: coef_o = 5'd0;   7'd19: coef_o = 5'd17;  7'd20: coef_o = 5'd26;
      7'd21: coef_o = 5'd0;   7'd22: coef_o = 5'd3;   7'd23: coef_o = 5'd12;
      7'd24: coef_o = 5'd0;   7'd25: coef_o = 5'd18;  7'd26: coef_o = 5'd22;
      7'd27: coef_o = 5'd0;   7'd28: coef_o = 5'd12;  7'd29: coef_o = 5'd18;
      7'd30: coef_o = 5'd0;   7'd31: coef_o = 5'd4;   7'd32: coef_o = 5'd7;
      7'd33: coef_o = 5'd0;   7'd34: coef_o = 5'd4;   7'd35: coef_o = 5'd31;
      7'd36: coef_o = 5'd0;   7'd37: coef_o = 5'd12;  7'd38: coef_o = 5'd27;
      7'd39: coef_o = 5'd0;   7'd40: coef_o = 5'd7;   7'd41: coef_o = 5'd17;
      7'd42: coef_o = 5'd0;   7'd43: coef_o = 5'd7;   7'd44: coef_o = 5'd8;
      7'd45: coef_o = 5'd0;   7'd46: coef_o = 5'd7;   7'd47: coef_o = 5'd13;
      default: coef_o = '0;
    endcase
  end

endmodule

// File: rtl/eaglesong_circulant_mult.sv
// Word-serial Eaglesong circulant multiplication: one word per cycle through a
// single rotate/XOR unit; result valid 16 edges after accept, held until out_ready.
module eaglesong_circulant_mult
  import eaglesong_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_state,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_state,
  output logic               busy
);

  state_e             st_q;
  logic [3:0]         cnt_q;
  logic [STATE_W-1:0] state_q;
  logic               out_valid_q;

  logic [IDX_W-1:0]   idx_a, idx_b;
  logic [COEF_W-1:0]  coef_a, coef_b;
  logic [WORD_W-1:0]  word_cur, word_d;
  logic [8:0]         word_base;

  assign idx_a = ({3'b000, cnt_q} * 7'd3) + 7'd1;
  assign idx_b = ({3'b000, cnt_q} * 7'd3) + 7'd2;

  eaglesong_coefficients u_coef_a (
    .idx_i  (idx_a),
    .coef_o (coef_a)
  );

  eaglesong_coefficients u_coef_b (
    .idx_i  (idx_b),
    .coef_o (coef_b)
  );

  assign word_base = {cnt_q, 5'b00000};

  always_comb begin
    word_cur = state_q[word_base +: WORD_W];
    word_d   = word_cur ^ rotl32(word_cur, coef_a) ^ rotl32(word_cur, coef_b);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q        <= ST_IDLE;
      cnt_q       <= '0;
      state_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (st_q)
        ST_IDLE: begin
          if (in_valid) begin
            state_q <= in_state;
            cnt_q   <= '0;
            st_q    <= ST_RUN;
          end
        end
        ST_RUN: begin
          state_q[word_base +: WORD_W] <= word_d;
          cnt_q                        <= cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            st_q        <= ST_DONE;
            out_valid_q <= 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            st_q        <= ST_IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          st_q        <= ST_IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Gating with reset keeps in_ready low for the whole reset pulse, not just after an edge.
  assign in_ready  = (st_q == ST_IDLE) && !reset;
  assign busy      = (st_q == ST_RUN) || (st_q == ST_DONE);
  assign out_valid = out_valid_q;
  assign out_state = state_q;

endmodule

// File: tb/tb_eaglesong_circulant_mult.sv
// Directed bench for eaglesong_circulant_mult with hand-computed vectors and a
// small reference model of the circulant step.
module tb_eaglesong_circulant_mult;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [511:0] in_state;
  logic         out_valid;
  logic         out_ready;
  logic [511:0] out_state;
  logic         busy;

  int total = 0;
  int bad   = 0;

  int unsigned coef_tb [48] = '{
    0, 2, 4,   0, 13, 22,  0, 4, 19,  0, 3, 14,
    0, 27, 31, 0, 3, 8,    0, 17, 26, 0, 3, 12,
    0, 18, 22, 0, 12, 18,  0, 4, 7,   0, 4, 31,
    0, 12, 27, 0, 7, 17,   0, 7, 8,   0, 7, 13};

  eaglesong_circulant_mult dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rl(input logic [31:0] x, input int unsigned n);
    if (n == 0) return x;
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [511:0] model(input logic [511:0] s);
    logic [511:0] r;
    logic [31:0]  w;
    r = s;
    for (int i = 0; i < 16; i++) begin
      w = s[32*i +: 32];
      r[32*i +: 32] = w ^ rl(w, coef_tb[3*i+1]) ^ rl(w, coef_tb[3*i+2]);
    end
    return r;
  endfunction

  function automatic logic [511:0] fill(input logic [31:0] w);
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = w;
    return r;
  endfunction

  // Accept one state, measure latency, check result, then complete the handshake.
  task automatic run_one(input string tag, input logic [511:0] data, input logic [511:0] exp);
    int lat;
    @(negedge clk);
    chk({tag, "_rdy"}, {511'b0, in_ready}, 512'd1);
    in_valid = 1'b1;
    in_state = data;
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, "_busy"}, {511'b0, busy}, 512'd1);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, 512'(lat), 512'd16);
    chk({tag, "_res"}, out_state, exp);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_vld_clr"}, {511'b0, out_valid}, 512'd0);
    chk({tag, "_idle_rdy"}, {511'b0, in_ready}, 512'd1);
  endtask

  logic [511:0] pat_a, pat_b, held;
  int           acc_e [4];
  logic [511:0] res   [4];
  int           nacc, nres;
  logic         bump;

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_state = '0;
    #1;
    chk("rst_rdy",  {511'b0, in_ready},  512'd0);
    chk("rst_vld",  {511'b0, out_valid}, 512'd0);
    chk("rst_busy", {511'b0, busy},      512'd0);
    chk("rst_out",  out_state,           512'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    run_one("zero", '0, '0);

    run_one("ones", fill(32'h1), model(fill(32'h1)));
    chk("w0",  {480'b0, out_state[31:0]},    {480'b0, 32'h00000015});
    chk("w4",  {480'b0, out_state[159:128]}, {480'b0, 32'h88000001});
    chk("w15", {480'b0, out_state[511:480]}, {480'b0, 32'h00002081});

    for (int i = 0; i < 16; i++) pat_a[32*i +: 32] = (32'h11111111 * i) ^ 32'hdeadbeef;
    run_one("mix", pat_a, model(pat_a));

    // DONE hold with out_ready low
    @(negedge clk);
    in_valid = 1'b1; in_state = fill(32'h80000001);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (16) @(negedge clk);
    chk("hold_vld0", {511'b0, out_valid}, 512'd1);
    held = model(fill(32'h80000001));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_vld", {511'b0, out_valid}, 512'd1);
      chk("hold_dat", out_state, held);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("hold_rel_vld", {511'b0, out_valid}, 512'd0);
    chk("hold_rel_rdy", {511'b0, in_ready},  512'd1);

    // in_valid with fresh data during RUN is ignored
    pat_b = fill(32'hcafef00d);
    @(negedge clk);
    in_valid = 1'b1; in_state = pat_a;
    @(negedge clk);
    for (int k = 0; k < 15; k++) begin
      in_valid = k[0];
      in_state = pat_b ^ 512'(k);
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("ign_vld", {511'b0, out_valid}, 512'd1);
    chk("ign_res", out_state, model(pat_a));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // reset mid-run at cnt = 7
    @(negedge clk);
    in_valid = 1'b1; in_state = pat_b;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mrst_vld",  {511'b0, out_valid}, 512'd0);
    chk("mrst_busy", {511'b0, busy},      512'd0);
    chk("mrst_rdy",  {511'b0, in_ready},  512'd0);
    chk("mrst_out",  out_state,           512'd0);
    @(negedge clk);
    reset = 1'b0;
    begin
      int seen = 0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (out_valid) seen++;
      end
      chk("mrst_noout", 512'(seen), 512'd0);
    end
    run_one("post_rst", pat_b, model(pat_b));

    // back-to-back with in_valid and out_ready held high
    nacc = 0; nres = 0;
    @(negedge clk);
    in_valid = 1'b1; in_state = pat_a; out_ready = 1'b1;
    for (int e = 0; e < 60; e++) begin
      bump = 1'b0;
      if (in_ready && in_valid && nacc < 4) begin
        acc_e[nacc] = e; nacc++; bump = 1'b1;
      end
      if (out_valid && nres < 4) begin
        res[nres] = out_state; nres++;
      end
      @(posedge clk);
      #1;
      if (bump) in_state = (nacc == 1) ? pat_b : pat_a;
      if (nacc >= 2) in_valid = 1'b0;
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk("b2b_nacc", 512'(nacc), 512'd2);
    chk("b2b_nres", 512'(nres), 512'd2);
    chk("b2b_ii",   512'(acc_e[1] - acc_e[0]), 512'd18);
    chk("b2b_res0", res[0], model(pat_a));
    chk("b2b_res1", res[1], model(pat_b));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/eaglesong_circulant_mult.md
EAGLESONG_CIRCULANT_MULT -- requirements
Module: eaglesong_circulant_mult

Interface
REQ-001 Parameters: none; all widths come from the shared package.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 in_valid  in  1  upstream presents a state on in_state.
REQ-005 in_ready  out  1  block accepts a state this cycle.
REQ-006 in_state  in  512  word i = in_state[32*i+31:32*i], i = 0..15.
REQ-007 out_valid  out  1  out_state holds a finished result.
REQ-008 out_ready  in  1  downstream accepts out_state.
REQ-009 out_state  out  512  result, same word packing as in_state.
REQ-010 busy  out  1  high in RUN and DONE.

Function
REQ-011 The block SHALL implement the Eaglesong circulant-multiplication step: for each word i, w'[i] = w[i] XOR rotl(w[i], C[3i+1]) XOR rotl(w[i], C[3i+2]).
- C[] is the 48-entry 5-bit table of eaglesong_coefficients.
- C[3i] = 0 is unused.
- rotl is a 32-bit rotate-left; a rotate amount of 0 is identity.
REQ-012 FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-013 IDLE: in_ready = 1 (forced 0 while reset is high).
- When in_valid && in_ready on an edge: latch in_state into the internal 512-bit register, set word counter cnt to 0, go to RUN.
REQ-014 RUN: in_ready = 0.
- Each edge replaces word[cnt] with w'[cnt] and increments cnt.
- The edge with cnt = 15 goes to DONE.
REQ-015 Coefficient indices SHALL be 3*cnt+1 and 3*cnt+2, 7 bits wide, always within 1..47.
REQ-016 DONE: out_valid = 1 and out_state = internal register.
- On an edge with out_ready = 1: go to IDLE and clear out_valid.
- Otherwise hold out_state and out_valid unchanged.
REQ-017 Latency: out_valid SHALL rise exactly 16 rising edges after the accepting edge.
- Minimum initiation interval is 18 cycles (accept edge, 16 RUN edges, output-handshake edge).
REQ-018 in_valid in RUN or DONE SHALL be ignored, with no effect on the internal register.
REQ-019 out_ready asserted outside DONE SHALL have no effect.
REQ-020 Words not yet processed SHALL keep their latched values; words already processed SHALL not be modified again.
REQ-021 out_state SHALL be driven from the internal register in every state; only its value in DONE is meaningful.

Reset
REQ-022 Asserting reset SHALL immediately, without waiting for clk:
- set FSM = IDLE, cnt = 0, out_valid = 0, busy = 0, in_ready = 0, internal register = 0 (so out_state = 0).
REQ-023 Reset in RUN or DONE SHALL abandon the operation, producing no out_valid pulse.
REQ-024 After reset is released, the first rising edge with in_valid = 1 SHALL be accepted.

Structure
REQ-025 Shared package eaglesong_pkg SHALL hold:
- WORD_W = 32, NUM_WORDS = 16, STATE_W = 512, COEF_W = 5, IDX_W = 7;
- the FSM state typedef;
- a rotl32 function.
REQ-026 The module SHALL instantiate the existing eaglesong_coefficients sub-module twice, one instance per rotate amount, as combinational lookups.
- No other sub-module.
REQ-027 Datapath: one word-wide XOR/rotate unit muxed by cnt; no 16-way parallel datapath.

Verification
REQ-028 All in_state = 0 -> after 16 cycles out_valid = 1, out_state = 0.
REQ-029 All words = 0x00000001 -> word0 = 0x00000015 (C = 2, 4), word4 = 0x88000001 (C = 27, 31), word15 = 0x00002081 (C = 7, 13).
REQ-030 out_ready held low 5 cycles in DONE -> out_valid and out_state stable throughout; with out_ready high the next cycle -> IDLE, in_ready = 1 on the following cycle.
REQ-031 in_valid toggled with new data during RUN -> result equals that of the first accepted state only.
REQ-032 reset pulsed at cnt = 7 -> out_valid, busy, in_ready and out_state go to 0 asynchronously; no result emitted; a new state is accepted after release.
REQ-033 Two back-to-back transactions with in_valid and out_ready held high -> second accepted 18 cycles after the first; both results match the software model.
